// File: rtl/itlb_walker.sv
// Instruction-TLB miss walker: fetches the PTE for a missing user-mode page and
// refills the iTLB or raises a page fault. Optional watchdog: ITLB_WALKER_TIMEOUT_EN.
module itlb_walker #(
  parameter int VPN_W          = 20,
  parameter int PPN_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              tlb_miss,
  input  logic              supervisor_mode,
  input  logic [31:0]       VirtualAddress,
  input  logic [31:0]       ptbr,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              tlb_write,
  output logic [VPN_W-1:0]  reg_logic_page,
  output logic [PPN_W-1:0]  reg_physical_page,
  output logic              page_fault,
  output logic [31:0]       fault_vaddr,
  output logic              busy,
  output logic              walk_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               flush_pend_q, flush_pend_d;
  logic [31:0]        vaddr_q, vaddr_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               pte_v_q, pte_v_d;
  logic               pte_u_q, pte_u_d;
  logic [PPN_W-1:0]   pte_ppn_q, pte_ppn_d;
  logic [VPN_W-1:0]   lpage_q, lpage_d;
  logic [PPN_W-1:0]   ppage_q, ppage_d;
  logic               walk_error_c;
  logic [31:0]        pte_offset;
  logic               pte_ok;
  logic               unused_ok;

  // VPN scaled to a 4-byte PTE index, zero-extended; the add wraps modulo 2^32.
  assign pte_offset = {10'b0, VirtualAddress[31:12], 2'b00};
  assign pte_ok     = pte_v_q & pte_u_q;

`ifdef ITLB_WALKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign unused_ok = ^mem_rdata;
`else
  assign unused_ok = ^{mem_rdata, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    vaddr_d      = vaddr_q;
    mem_addr_d   = mem_addr_q;
    pte_v_d      = pte_v_q;
    pte_u_d      = pte_u_q;
    pte_ppn_d    = pte_ppn_q;
    lpage_d      = lpage_q;
    ppage_d      = ppage_q;
    walk_error_c = 1'b0;
`ifdef ITLB_WALKER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!flush && tlb_miss && !supervisor_mode) begin
          vaddr_d      = VirtualAddress;
          mem_addr_d   = ptbr + pte_offset;
          flush_pend_d = 1'b0;
          state_d      = S_REQ;
`ifdef ITLB_WALKER_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      S_REQ: begin
        // A flushed request stays on the bus until acked, then its data is dropped.
        if (flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          pte_v_d      = mem_rdata[0];
          pte_u_d      = mem_rdata[1];
          pte_ppn_d    = mem_rdata[12 +: PPN_W];
          flush_pend_d = 1'b0;
          state_d      = (flush || flush_pend_q) ? S_IDLE : S_CHECK;
        end
`ifdef ITLB_WALKER_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          walk_error_c = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_CHECK: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!pte_ok) begin
          state_d = S_DONE;
        end else begin
          lpage_d = vaddr_q[31 -: VPN_W];
          ppage_d = pte_ppn_q;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        // The iTLB miss flag is stale for this cycle, so it is not sampled.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      vaddr_q      <= '0;
      mem_addr_q   <= '0;
      pte_v_q      <= 1'b0;
      pte_u_q      <= 1'b0;
      pte_ppn_q    <= '0;
      lpage_q      <= '0;
      ppage_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      vaddr_q      <= vaddr_d;
      mem_addr_q   <= mem_addr_d;
      pte_v_q      <= pte_v_d;
      pte_u_q      <= pte_u_d;
      pte_ppn_q    <= pte_ppn_d;
      lpage_q      <= lpage_d;
      ppage_q      <= ppage_d;
    end
  end

`ifdef ITLB_WALKER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  assign walk_error = walk_error_c;
`else
  assign walk_error = 1'b0;
`endif

  // Strobes are gated by flush so an abort in CHECK/WRITE never leaks a pulse.
  assign mem_req           = (state_q == S_REQ);
  assign busy              = (state_q != S_IDLE);
  assign tlb_write         = (state_q == S_WRITE) && !flush;
  assign page_fault        = (state_q == S_CHECK) && !flush && !pte_ok;
  assign mem_addr          = mem_addr_q;
  assign reg_logic_page    = lpage_q;
  assign reg_physical_page = ppage_q;
  assign fault_vaddr       = vaddr_q;

endmodule

// File: tb/tb_itlb_walker.sv
// Self-checking bench for itlb_walker: a timeline model builds the expected
// outputs for every cycle of each directed walk and one process compares them.
module tb_itlb_walker;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        tlb_miss;
  logic        supervisor_mode;
  logic [31:0] VirtualAddress;
  logic [31:0] ptbr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        tlb_write;
  logic [19:0] reg_logic_page;
  logic [7:0]  reg_physical_page;
  logic        page_fault;
  logic [31:0] fault_vaddr;
  logic        busy;
  logic        walk_error;

  itlb_walker #(.VPN_W(20), .PPN_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .tlb_miss          (tlb_miss),
    .supervisor_mode   (supervisor_mode),
    .VirtualAddress    (VirtualAddress),
    .ptbr              (ptbr),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .tlb_write         (tlb_write),
    .reg_logic_page    (reg_logic_page),
    .reg_physical_page (reg_physical_page),
    .page_fault        (page_fault),
    .fault_vaddr       (fault_vaddr),
    .busy              (busy),
    .walk_error        (walk_error)
  );

  typedef struct packed {
    logic        req;
    logic        busy;
    logic        wr;
    logic        pf;
    logic        werr;
    logic        chk_fva;
    logic [31:0] addr;
    logic [19:0] lp;
    logic [7:0]  pp;
    logic [31:0] fva;
  } exp_t;

  exp_t        exp_cur;
  logic        exp_on;
  int          n_pass;
  int          n_total;

  // Values the outputs are expected to hold between events.
  logic [31:0] m_addr;
  logic [19:0] m_lp;
  logic [7:0]  m_pp;
  logic [31:0] m_fva;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic exp_t mk(input bit req, input bit bsy);
    exp_t e;
    e.req = req;  e.busy = bsy;  e.wr = 1'b0;  e.pf = 1'b0;  e.werr = 1'b0;
    e.chk_fva = 1'b0;
    e.addr = m_addr;  e.lp = m_lp;  e.pp = m_pp;  e.fva = m_fva;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      chk("mem_req",           {31'b0, mem_req},    {31'b0, exp_cur.req});
      chk("busy",              {31'b0, busy},       {31'b0, exp_cur.busy});
      chk("tlb_write",         {31'b0, tlb_write},  {31'b0, exp_cur.wr});
      chk("page_fault",        {31'b0, page_fault}, {31'b0, exp_cur.pf});
      chk("walk_error",        {31'b0, walk_error}, {31'b0, exp_cur.werr});
      chk("mem_addr",          mem_addr,            exp_cur.addr);
      chk("reg_logic_page",    {12'b0, reg_logic_page},   {12'b0, exp_cur.lp});
      chk("reg_physical_page", {24'b0, reg_physical_page}, {24'b0, exp_cur.pp});
      if (exp_cur.chk_fva) chk("fault_vaddr", fault_vaddr, exp_cur.fva);
    end
  end

  // Apply one cycle of inputs together with the outputs expected in that cycle.
  task automatic drive(input bit miss, input bit sup, input bit fl, input bit ack,
                       input bit rst, input logic [31:0] rdata, input logic [31:0] va,
                       input logic [31:0] pt, input exp_t e);
    @(posedge clk);
    #1;
    tlb_miss = miss;  supervisor_mode = sup;  flush = fl;  mem_ack = ack;
    reset = rst;  mem_rdata = rdata;  VirtualAddress = va;  ptbr = pt;
    exp_cur = e;
    exp_on  = 1'b1;
  endtask

  // fphase: 0 none, 1 flush in REQ cycle fat, 2 flush in CHECK, 3 flush in WRITE.
  // rat: REQ cycle index carrying a reset pulse, -1 for none.
  task automatic walk(input logic [31:0] pt, input logic [31:0] va, input logic [31:0] rdata,
                      input int wait_n, input int fphase, input int fat, input int rat);
    exp_t e;
    bit   ok;
    bit   flushed;
    drive(1, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
    m_addr  = pt + {10'b0, va[31:12], 2'b00};
    m_fva   = va;
    flushed = 1'b0;
    for (int i = 0; i <= wait_n; i++) begin
      bit a;
      bit f;
      bit r;
      a = (i == wait_n);
      f = (fphase == 1) && (i == fat);
      r = (i == rat);
      drive(0, 0, f, a, r, a ? rdata : ~rdata, ~va, ~pt, mk(1, 1));
      if (r) begin
        m_addr = '0;  m_lp = '0;  m_pp = '0;  m_fva = '0;
        e = mk(0, 0);
        e.chk_fva = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0, va, pt, e);
        return;
      end
      flushed = flushed | f;
    end
    if (flushed) begin
      drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
      return;
    end
    ok = rdata[0] & rdata[1];
    e  = mk(0, 1);
    if (fphase == 2) begin
      drive(0, 0, 1, 0, 0, 32'h0, va, pt, e);
      drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
      return;
    end
    e.pf      = !ok;
    e.chk_fva = !ok;
    drive(0, 0, 0, 0, 0, 32'h0, va, pt, e);
    if (ok) begin
      m_lp = va[31:12];
      m_pp = rdata[19:12];
      e    = mk(0, 1);
      if (fphase == 3) begin
        drive(0, 0, 1, 0, 0, 32'h0, va, pt, e);
        drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
        return;
      end
      e.wr = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0, va, pt, e);
    end
    drive(1, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 1));
    drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
  endtask

  task automatic gate(input bit sup, input bit fl);
    drive(1, sup, fl, 0, 0, 32'h0, 32'h1234_5678, 32'h0002_0000, mk(0, 0));
    drive(1, sup, fl, 0, 0, 32'h0, 32'h1234_5678, 32'h0002_0000, mk(0, 0));
    drive(0, 0, 0, 0, 0, 32'h0, 32'h1234_5678, 32'h0002_0000, mk(0, 0));
  endtask

`ifdef ITLB_WALKER_TIMEOUT_EN
  task automatic tmo(input logic [31:0] pt, input logic [31:0] va);
    exp_t e;
    drive(1, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
    m_addr = pt + {10'b0, va[31:12], 2'b00};
    m_fva  = va;
    for (int i = 0; i <= TO; i++) begin
      e = mk(1, 1);
      e.werr = (i == TO);
      drive(0, 0, 0, 0, 0, 32'h0, va, pt, e);
    end
    drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
    drive(0, 0, 0, 0, 0, 32'h0, va, pt, mk(0, 0));
  endtask
`endif

  initial begin
    n_pass = 0;  n_total = 0;  exp_on = 1'b0;
    m_addr = '0;  m_lp = '0;  m_pp = '0;  m_fva = '0;
    reset = 1'b1;  flush = 1'b0;  tlb_miss = 1'b0;  supervisor_mode = 1'b0;
    VirtualAddress = '0;  ptbr = '0;  mem_ack = 1'b0;  mem_rdata = '0;
    exp_cur = '0;

    // Reset state: every output zero, fault_vaddr included.
    begin
      exp_t e;
      e = mk(0, 0);
      e.chk_fva = 1'b1;
      drive(1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, e);
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, e);
    end

    // Basic refill, ack in the 4th REQ cycle.
    walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_5003, 3, 0, 0, -1);
    @(negedge clk);
    chk("lit_mem_addr", mem_addr, 32'h0001_100C);
    chk("lit_logic_page", {12'b0, reg_logic_page}, 32'h0000_0403);
    chk("lit_physical_page", {24'b0, reg_physical_page}, 32'h0000_0025);

    // Invalid PTE and non-user PTE both fault.
    walk(32'h0001_0000, 32'h0040_3ABC, 32'h0002_5002, 1, 0, 0, -1);
    @(negedge clk);
    chk("lit_fault_vaddr", fault_vaddr, 32'h0040_3ABC);
    walk(32'h0001_0000, 32'h0077_7004, 32'h0002_5001, 0, 0, 0, -1);

    // Supervisor-mode and flushed misses never start a walk.
    gate(1, 0);
    gate(0, 1);

    // Zero-wait ack with PTE address wrapping past the top of memory.
    walk(32'hFFFF_F000, 32'hFFFF_F123, 32'hFFFF_FFFF, 0, 0, 0, -1);
    @(negedge clk);
    chk("lit_wrap_addr", mem_addr, 32'h003F_EFFC);
    chk("lit_wrap_ppn", {24'b0, reg_physical_page}, 32'h0000_00FF);
    chk("lit_wrap_vpn", {12'b0, reg_logic_page}, 32'h000F_FFFF);

    // Flush during REQ, CHECK and WRITE.
    walk(32'h0003_0000, 32'h0012_3000, 32'h0004_4003, 3, 1, 1, -1);
    walk(32'h0003_0000, 32'h0012_4000, 32'h0004_5003, 0, 1, 0, -1);
    walk(32'h0003_0000, 32'h0012_5000, 32'h0004_6003, 1, 2, 0, -1);
    walk(32'h0003_0000, 32'h0012_6000, 32'h0004_7003, 1, 3, 0, -1);

    // Refill after the aborts, then reset in the middle of REQ.
    walk(32'h0005_0000, 32'h00AB_C000, 32'h0009_A003, 2, 0, 0, -1);
    walk(32'h0005_0000, 32'h00AB_D000, 32'h0009_B003, 3, 0, 0, 1);

`ifdef ITLB_WALKER_TIMEOUT_EN
    tmo(32'h0006_0000, 32'h0011_1000);
    walk(32'h0006_0000, 32'h0011_2000, 32'h0001_2003, TO, 0, 0, -1);
`else
    walk(32'h0006_0000, 32'h0011_1000, 32'h0001_1003, 10, 0, 0, -1);
`endif

    @(negedge clk);
    @(negedge clk);
    exp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
